// File: rtl/hoaaned_pkg.sv
// Shared types and helpers for the pipelined HOAANED approximate adder.
// Build option: define HOAANED_ERRMON_EN to compile in the error monitor.
package hoaaned_pkg;

  localparam int unsigned MAX_W      = 64;
  localparam int unsigned DEF_N      = 16;
  localparam int unsigned DEF_LPL    = 6;
  localparam int unsigned DEF_STAGES = 2;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             carry;
  } lsb_t;

  // Approximate lower part: top two bits computed, the rest forced to one.
  function automatic lsb_t approx_lsb(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input int unsigned      l);
    lsb_t       r;
    logic [5:0] ih;
    logic [5:0] il;
    logic       c;
    logic       s_hi;
    logic       s_lo;
    ih      = 6'(l - 1);
    il      = 6'(l - 2);
    c       = a[ih] & b[ih];
    s_lo    = a[il] | b[il];
    s_hi    = (c ? 1'b0 : (a[ih] | b[ih])) | (a[il] & b[il]);
    r.sum   = (MAX_W'(1) << (l - 2)) - MAX_W'(1);
    r.sum   = r.sum | (MAX_W'(s_lo) << (l - 2)) | (MAX_W'(s_hi) << (l - 1));
    r.carry = c;
    return r;
  endfunction

  // Upper-part slice width: ceiling split of the precise bits over the stages.
  function automatic int unsigned slice_width(input int unsigned n,
                                              input int unsigned lpl,
                                              input int unsigned stages);
    return (n - lpl + stages - 1) / stages;
  endfunction

  // First bit of slice k, clamped to the operand width.
  function automatic int unsigned slice_lo(input int unsigned k,
                                           input int unsigned n,
                                           input int unsigned lpl,
                                           input int unsigned stages);
    int unsigned lo;
    lo = lpl + k * slice_width(n, lpl, stages);
    return (lo > n) ? n : lo;
  endfunction

  // One past the last bit of slice k; the last slice absorbs the remainder.
  function automatic int unsigned slice_hi(input int unsigned k,
                                           input int unsigned n,
                                           input int unsigned lpl,
                                           input int unsigned stages);
    int unsigned hi;
    if (k == stages - 1) return n;
    hi = slice_lo(k, n, lpl, stages) + slice_width(n, lpl, stages);
    return (hi > n) ? n : hi;
  endfunction

endpackage

// File: rtl/hoaaned_stage.sv
// One pipeline slice: adds bits [HI-1:LO] and registers operands, sum, carry.
module hoaaned_stage #(
  parameter int unsigned N  = 16,
  parameter int unsigned LO = 6,
  parameter int unsigned HI = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         v_in,
  input  logic         exact_in,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] sum_in,
  input  logic         c_in,
  output logic         v_q,
  output logic         exact_q,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [N-1:0] sum_q,
  output logic         c_q
);

  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] SLICE_M = (W'(1) << HI) - (W'(1) << LO);
  localparam logic [W-1:0] CARRY_M = W'(1) << HI;

  logic [W-1:0] add_s;
  logic [N-1:0] sum_d;
  logic         c_d;

  // Masked add of this slice; an empty slice just forwards the carry.
  always_comb begin
    add_s = (W'(a_in) & SLICE_M) + (W'(b_in) & SLICE_M) + (W'(c_in) << LO);
    sum_d = (sum_in & ~SLICE_M[N-1:0]) | (add_s[N-1:0] & SLICE_M[N-1:0]);
    c_d   = |(add_s & CARRY_M);
  end

  // Stage register, advanced only by the global enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      exact_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
    end else if (adv) begin
      v_q     <= v_in;
      exact_q <= exact_in;
      a_q     <= a_in;
      b_q     <= b_in;
      sum_q   <= sum_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: rtl/hoaaned_pipe.sv
// Pipelined HOAANED adder: approximate/precise lower part, staged upper ripple.
// Build option: HOAANED_ERRMON_EN adds err_clr/err_max and a reference adder.
module hoaaned_pipe
  import hoaaned_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned LPL    = DEF_LPL,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum,
  output logic         out_exact
`ifdef HOAANED_ERRMON_EN
  ,
  input  logic         err_clr,
  output logic [N:0]   err_max
`endif
);

  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned LW   = LPL + 1;

  logic         adv;
  lsb_t         lsb;
  logic [LPL:0] low_ex;
  logic [LPL-1:0] low_sum;
  logic         low_c;

  logic         v_i   [STAGES];
  logic         ex_i  [STAGES];
  logic [N-1:0] a_i   [STAGES];
  logic [N-1:0] b_i   [STAGES];
  logic [N-1:0] sum_i [STAGES];
  logic         c_i   [STAGES];

  logic         v_s   [STAGES];
  logic         ex_s  [STAGES];
  logic [N-1:0] a_s   [STAGES];
  logic [N-1:0] b_s   [STAGES];
  logic [N-1:0] sum_s [STAGES];
  logic         c_s   [STAGES];

  logic         unused_ok;

  // Single global advance; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Lower part: approximate cell or true ripple add, chosen per beat.
  always_comb begin
    lsb     = approx_lsb(MAX_W'(in_a), MAX_W'(in_b), LPL);
    low_ex  = LW'(in_a[LPL-1:0]) + LW'(in_b[LPL-1:0]);
    low_sum = in_exact ? low_ex[LPL-1:0] : lsb.sum[LPL-1:0];
    low_c   = in_exact ? low_ex[LPL] : lsb.carry;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = slice_lo(k, N, LPL, STAGES);
    localparam int unsigned HI = slice_hi(k, N, LPL, STAGES);

    if (k == 0) begin : g_head
      assign v_i[k]   = in_valid;
      assign ex_i[k]  = in_exact;
      assign a_i[k]   = in_a;
      assign b_i[k]   = in_b;
      assign sum_i[k] = N'(low_sum);
      assign c_i[k]   = low_c;
    end else begin : g_body
      assign v_i[k]   = v_s[k-1];
      assign ex_i[k]  = ex_s[k-1];
      assign a_i[k]   = a_s[k-1];
      assign b_i[k]   = b_s[k-1];
      assign sum_i[k] = sum_s[k-1];
      assign c_i[k]   = c_s[k-1];
    end

    hoaaned_stage #(
      .N  (N),
      .LO (LO),
      .HI (HI)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .v_in     (v_i[k]),
      .exact_in (ex_i[k]),
      .a_in     (a_i[k]),
      .b_in     (b_i[k]),
      .sum_in   (sum_i[k]),
      .c_in     (c_i[k]),
      .v_q      (v_s[k]),
      .exact_q  (ex_s[k]),
      .a_q      (a_s[k]),
      .b_q      (b_s[k]),
      .sum_q    (sum_s[k]),
      .c_q      (c_s[k])
    );
  end

  assign out_valid = v_s[LAST];
  assign out_sum   = {c_s[LAST], sum_s[LAST]};
  assign out_exact = ex_s[LAST];

  // Operand copies leave the last stage only for the monitor.
  assign unused_ok = ^{lsb.sum[MAX_W-1:LPL], a_s[LAST], b_s[LAST]};

`ifdef HOAANED_ERRMON_EN
  localparam int unsigned W = N + 1;

  logic [N:0] ref_sum;
  logic [N:0] err_d;

  // Exact reference from the operands travelling with the emitted beat.
  always_comb begin
    ref_sum = W'(a_s[LAST]) + W'(b_s[LAST]);
    err_d   = (ref_sum >= out_sum) ? (ref_sum - out_sum) : (out_sum - ref_sum);
  end

  // Running maximum of absolute error over handshaken results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max <= '0;
    end else if (err_clr) begin
      err_max <= '0;
    end else if (out_valid && out_ready && (err_d > err_max)) begin
      err_max <= err_d;
    end
  end
`endif

endmodule

// File: doc/hoaaned_pipe.md
# hoaaned_pipe

Pipelined, parametrised successor to the combinational HOAANED approximate adder.
- Adds two N-bit operands with an approximate lower part and a precise upper part, or with a fully precise path when selected per transaction.
- The upper carry chain is split across STAGES register stages, with valid/ready handshakes on both sides.
- Sits between operand producers (MAC/filter datapaths) and result consumers in the approximate-arithmetic library.

## Interface
- N, 16, operand width; result width is N+1.
- LPL, 6, approximate lower-part width; legal range 2 ≤ LPL < N.
- STAGES, 2, pipeline depth; legal range 1 ≤ STAGES ≤ N−LPL.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a, in_b  in  N  operands (unsigned).
- in_exact  in  1  1 = fully precise add for this beat; 0 = approximate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  N+1  sum including carry-out.
- out_exact  out  1  in_exact echoed with the result.

## Operation
- Approximate lower part (bits LPL−1:0, in_exact=0):
  - c = a[L−1]&b[L−1].
  - s[L−1] = (c ? 0 : a[L−1]|b[L−1]) | (a[L−2]&b[L−2]).
  - s[L−2] = a[L−2]|b[L−2].
  - s[L−3:0] = all ones.
  - c is the carry-in to the upper part.
- Precise mode (in_exact=1): the lower part is a true ripple add with carry-in 0, and its carry-out feeds the upper part.
- Upper part (bits N−1:LPL): ripple-carry, split into STAGES slices.
  - Slice width is ceil((N−LPL)/STAGES); the last slice takes the remainder.
  - Stage k adds slice k with the carry registered from stage k−1.
  - Unprocessed operand slices and finished sum slices travel alongside in skew registers.
- out_sum[N] = final upper carry-out.
- Lower-part logic completes in stage 0.
- All arithmetic is unsigned and modulo-free: the N+1-bit result never truncates.
- Flow control is a single global advance:
  - adv = !out_valid | out_ready.
  - in_ready = adv.
  - On adv, every stage register loads from its predecessor and each stage valid bit shifts.
  - When adv=0, all stages hold.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. They never block younger beats behind an empty output.

## Timing
- Latency is exactly STAGES cycles from an accepted beat to out_valid when out_ready stays high.
- Throughput is one beat per cycle.
- Output stability: out_sum and out_exact hold stable while out_valid=1 and out_ready=0.
- in_ready is combinational from out_ready and out_valid only, with no path from in_valid.
- Simultaneous in_valid and a stalled output: the beat is not accepted and in_ready=0. The producer must hold its beat.
- Reset values: out_valid=0, out_sum=0, out_exact=0, all stage valid bits 0. in_ready=1 after reset.
- Reset asserted mid-operation flushes every in-flight beat, and none are emitted after release.
- STAGES=1: result registered once with latency 1, and the full upper chain sits in one stage.

## Configuration
- HOAANED_ERRMON_EN compiles in an error monitor:
  - Extra ports: err_clr (in, 1) and err_max (out, N+1).
  - Each emitted beat computes an exact reference sum in parallel.
  - On an out_valid & out_ready handshake, err_max = max(err_max, |exact − out_sum|).
  - err_clr synchronously zeroes err_max and has priority over an update in the same cycle.
  - err_max resets to 0.
- Without the macro, the monitor ports and the reference adder are absent, and timing and results are identical.

## Structure
- Shared package hoaaned_pkg holds:
  - Function approx_lsb(a, b, L), returning sum bits and carry.
  - Function slice_width(N, LPL, STAGES).
  - Localparams for the per-stage slice bounds.
- One sub-module, hoaaned_stage: one pipeline slice holding operand/sum skew registers, the carry register and the valid bit, with the global adv as enable.

## Test plan
- Defaults, approx: a=16'h003F, b=16'h0001 → out_sum=17'h0003F after 2 cycles. Monitor records err 1 (exact 0x40).
- Approx with lower-part carry: a=b=16'h0020 → out_sum=17'h0004F. Monitor err_max=15.
- Full-width carry, approx: a=b=16'hFFFF → out_sum=17'h1FFFF. With in_exact=1 → 17'h1FFFE, out_exact=1.
- Back-pressure: stream 8 random beats with out_ready low for cycles 3–6. No beat is lost or duplicated, order is preserved, and the result holds while stalled.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight. out_valid=0 immediately, nothing emitted after release, and in_ready=1.
- Sweep: N=8, LPL=2, STAGES=6 and STAGES=1 random regression against the reference model, in both modes.
